atm_controller: RTL and testbench
=================================

// Module: atm_controller
// PURPOSE
//  ATM transaction controller, driven by the ATM bench stimulus. Takes card-insert, keypad digit and amount strobes.
//  Checks a 4-digit PIN against PIN and counts failed attempts, with warning and lockout.
//  Runs deposit/withdrawal against an internal 64-bit balance and pulses the result flags back to the stimulus side.
// PARAMETERS
//  BALANCE_INICIAL  64'd5000  balance loaded on reset
//  MAX_INTENTOS     3         wrong PINs before BLOQUEO; ADVERTENCIA at MAX_INTENTOS-1
// PORTS
//  CLK                   in   1   system clock, rising edge
//  RESET                 in   1   asynchronous, active-low reset
//  TARJETA_RECIBIDA      in   1   card present (level)
//  PIN                   in   16  correct PIN, 4 BCD nibbles, [15:12] = first digit
//  DIGITO                in   4   keypad digit, valid when DIGITO_STB=1
//  DIGITO_STB            in   1   one-cycle digit strobe
//  TIPO_TRANS            in   1   0 = deposit, 1 = withdrawal; sampled with MONTO_STB
//  MONTO                 in   32  amount, unsigned; sampled with MONTO_STB
//  MONTO_STB             in   1   one-cycle amount strobe
//  PIN_INCORRECTO        out  1   1-cycle pulse per wrong PIN
//  ADVERTENCIA           out  1   level: failed attempts == MAX_INTENTOS-1
//  BLOQUEO               out  1   level: locked, held until RESET
//  BALANCE_ACTUALIZADO   out  1   1-cycle pulse when balance changes
//  ENTREGAR_DINERO       out  1   1-cycle pulse, withdrawal granted
//  FONDOS_INSUFICIENTES  out  1   1-cycle pulse, withdrawal refused
//  BALANCE               out  64  current balance
// BEHAVIOUR
//  Reset (RESET=0, async):
//   - state IDLE; digit count, shift reg and intentos = 0
//   - all 1-bit outputs 0; BALANCE = BALANCE_INICIAL
//  All outputs are registered.
//  States:
//   - IDLE: TARJETA_RECIBIDA=1 -> PIN_ENTRY; clear digit count and shift reg.
//   - PIN_ENTRY: each DIGITO_STB: sr <= {sr[11:0],DIGITO}, cnt++.
//     On the 4th strobe go to CHECK; compare occurs in CHECK.
//   - CHECK: one cycle; DIGITO_STB ignored.
//     sr==PIN: intentos=0, ADVERTENCIA=0 -> WAIT_TRANS.
//     Else: PIN_INCORRECTO=1 for this cycle, intentos++.
//       intentos==MAX_INTENTOS-1: ADVERTENCIA=1.
//       intentos==MAX_INTENTOS: -> BLOQUEO.
//       Otherwise: -> PIN_ENTRY, cnt=0.
//   - WAIT_TRANS: MONTO_STB=1 -> DONE, with flags asserted in DONE's first cycle (1-cycle latency):
//     deposit: BALANCE += MONTO (zero-ext); saturates at 2^64-1; BALANCE_ACTUALIZADO=1.
//     withdrawal, MONTO<=BALANCE: BALANCE -= MONTO; BALANCE_ACTUALIZADO=1, ENTREGAR_DINERO=1.
//     withdrawal, MONTO>BALANCE: FONDOS_INSUFICIENTES=1; balance unchanged.
//   - DONE: pulses drop after 1 cycle; further strobes ignored; TARJETA_RECIBIDA=0 -> IDLE.
//   - BLOQUEO: BLOQUEO=1; all inputs ignored; exit only by RESET.
//  Card removal: TARJETA_RECIBIDA=0 in PIN_ENTRY/CHECK/WAIT_TRANS -> IDLE.
//   - partial digits discarded
//   - intentos and ADVERTENCIA retained (cleared only by correct PIN or RESET)
//  Simultaneous events:
//   - MONTO_STB with TARJETA_RECIBIDA=0 in the same cycle: card removal wins, no transaction.
//   - DIGITO_STB with card falling: digit dropped.
//  MONTO_STB outside WAIT_TRANS and DIGITO_STB outside PIN_ENTRY are ignored.
// TESTING
//  T1 PIN=16'h3473, card=1, three tries 1-3-7-8:
//     -> PIN_INCORRECTO pulse x3; ADVERTENCIA=1 after 2nd; BLOQUEO=1 after 3rd.
//     -> Digits then ignored; RESET low clears all.
//  T2 After reset, digits 3-4-7-3, deposit MONTO=2000
//     -> BALANCE_ACTUALIZADO pulse; BALANCE=7000.
//  T3 Two wrong PINs, then 3-4-7-3, withdraw 2000
//     -> ADVERTENCIA clears on correct PIN; ENTREGAR_DINERO and BALANCE_ACTUALIZADO pulse; BALANCE=5000.
//  T4 Correct PIN, withdraw 10000
//     -> FONDOS_INSUFICIENTES pulse only; BALANCE stays 5000.
//  T5 Card removed after 2 digits, reinsert, 3-4-7-3 -> accepted (partial digits discarded).
//     Then MONTO_STB in the same cycle card drops -> no flags, balance unchanged.
//  T6 Async RESET asserted mid-WAIT_TRANS, between clock edges
//     -> outputs 0 immediately; BALANCE=5000; state IDLE.

Source files
------------

// File: rtl/atm_controller.sv
// ATM transaction controller: card/PIN sequencing with retry warning and lockout,
// plus deposit/withdrawal against a registered 64-bit balance.
module atm_controller #(
  parameter logic [63:0] BALANCE_INICIAL = 64'd5000,
  parameter int          MAX_INTENTOS    = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TARJETA_RECIBIDA,
  input  logic [15:0] PIN,
  input  logic [3:0]  DIGITO,
  input  logic        DIGITO_STB,
  input  logic        TIPO_TRANS,
  input  logic [31:0] MONTO,
  input  logic        MONTO_STB,
  output logic        PIN_INCORRECTO,
  output logic        ADVERTENCIA,
  output logic        BLOQUEO,
  output logic        BALANCE_ACTUALIZADO,
  output logic        ENTREGAR_DINERO,
  output logic        FONDOS_INSUFICIENTES,
  output logic [63:0] BALANCE
);

  localparam int IW = $clog2(MAX_INTENTOS + 1);

  typedef enum logic [2:0] {S_IDLE, S_PIN, S_CHECK, S_WAIT, S_DONE, S_LOCK} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [15:0]   sr_q, sr_d;
  logic [IW-1:0] int_q, int_d;
  logic          pinc_q, pinc_d, adv_q, adv_d, bloq_q, bloq_d;
  logic          act_q, act_d, ent_q, ent_d, fond_q, fond_d;
  logic [63:0]   bal_q, bal_d;

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [31:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {33'b0, b};
    return s[64] ? {64{1'b1}} : s[63:0];
  endfunction

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      int_q   <= '0;
      pinc_q  <= 1'b0;
      adv_q   <= 1'b0;
      bloq_q  <= 1'b0;
      act_q   <= 1'b0;
      ent_q   <= 1'b0;
      fond_q  <= 1'b0;
      bal_q   <= BALANCE_INICIAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      int_q   <= int_d;
      pinc_q  <= pinc_d;
      adv_q   <= adv_d;
      bloq_q  <= bloq_d;
      act_q   <= act_d;
      ent_q   <= ent_d;
      fond_q  <= fond_d;
      bal_q   <= bal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    int_d   = int_q;
    adv_d   = adv_q;
    bloq_d  = bloq_q;
    bal_d   = bal_q;
    pinc_d  = 1'b0;
    act_d   = 1'b0;
    ent_d   = 1'b0;
    fond_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (TARJETA_RECIBIDA) begin
          state_d = S_PIN;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      // Card removal outranks any strobe arriving in the same cycle.
      S_PIN: begin
        if (!TARJETA_RECIBIDA) begin
          state_d = S_IDLE;
        end else if (DIGITO_STB) begin
          sr_d  = {sr_q[11:0], DIGITO};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!TARJETA_RECIBIDA) begin
          state_d = S_IDLE;
        end else if (sr_q == PIN) begin
          int_d   = '0;
          adv_d   = 1'b0;
          state_d = S_WAIT;
        end else begin
          pinc_d = 1'b1;
          int_d  = int_q + IW'(1);
          adv_d  = (int_d == IW'(MAX_INTENTOS - 1));
          if (int_d == IW'(MAX_INTENTOS)) begin
            state_d = S_LOCK;
            bloq_d  = 1'b1;
          end else begin
            state_d = S_PIN;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (!TARJETA_RECIBIDA) begin
          state_d = S_IDLE;
        end else if (MONTO_STB) begin
          state_d = S_DONE;
          if (!TIPO_TRANS) begin
            bal_d = sat_add(bal_q, MONTO);
            act_d = 1'b1;
          end else if ({32'b0, MONTO} <= bal_q) begin
            bal_d = bal_q - {32'b0, MONTO};
            act_d = 1'b1;
            ent_d = 1'b1;
          end else begin
            fond_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!TARJETA_RECIBIDA) state_d = S_IDLE;
      end
      S_LOCK: ;
      default: state_d = S_IDLE;
    endcase
  end

  assign PIN_INCORRECTO       = pinc_q;
  assign ADVERTENCIA          = adv_q;
  assign BLOQUEO              = bloq_q;
  assign BALANCE_ACTUALIZADO  = act_q;
  assign ENTREGAR_DINERO      = ent_q;
  assign FONDOS_INSUFICIENTES = fond_q;
  assign BALANCE              = bal_q;

endmodule

// File: tb/tb_atm_controller.sv
// Directed bench for atm_controller: PIN retries/lockout, deposit, withdrawal,
// insufficient funds, card-removal races and asynchronous reset.
module tb_atm_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        TARJETA_RECIBIDA;
  logic [15:0] PIN;
  logic [3:0]  DIGITO;
  logic        DIGITO_STB;
  logic        TIPO_TRANS;
  logic [31:0] MONTO;
  logic        MONTO_STB;
  logic        PIN_INCORRECTO, ADVERTENCIA, BLOQUEO;
  logic        BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES;
  logic [63:0] BALANCE;

  int checks = 0;
  int errors = 0;

  atm_controller #(.BALANCE_INICIAL(64'd5000), .MAX_INTENTOS(3)) dut (
    .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .PIN(PIN),
    .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB), .TIPO_TRANS(TIPO_TRANS),
    .MONTO(MONTO), .MONTO_STB(MONTO_STB), .PIN_INCORRECTO(PIN_INCORRECTO),
    .ADVERTENCIA(ADVERTENCIA), .BLOQUEO(BLOQUEO),
    .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO), .ENTREGAR_DINERO(ENTREGAR_DINERO),
    .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES), .BALANCE(BALANCE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // flags = {PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, BAL_ACT, ENTREGAR, FONDOS}
  task automatic chk_flags(input string tag, input logic [5:0] exp);
    chk(tag, {58'd0, PIN_INCORRECTO, ADVERTENCIA, BLOQUEO,
              BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES}, {58'd0, exp});
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic digit(input logic [3:0] d);
    DIGITO = d;
    DIGITO_STB = 1'b1;
    step();
    DIGITO_STB = 1'b0;
  endtask

  // Four digits then the CHECK cycle; outputs afterwards show the verdict.
  task automatic enter_pin(input logic [15:0] p);
    digit(p[15:12]);
    digit(p[11:8]);
    digit(p[7:4]);
    digit(p[3:0]);
    step();
  endtask

  task automatic amount(input logic tipo, input logic [31:0] m);
    TIPO_TRANS = tipo;
    MONTO = m;
    MONTO_STB = 1'b1;
    step();
    MONTO_STB = 1'b0;
  endtask

  task automatic card_in();
    TARJETA_RECIBIDA = 1'b1;
    step();
  endtask

  task automatic card_out();
    TARJETA_RECIBIDA = 1'b0;
    step();
  endtask

  initial begin
    RESET = 1'b0; TARJETA_RECIBIDA = 1'b0; PIN = 16'h3473;
    DIGITO = 4'd0; DIGITO_STB = 1'b0; TIPO_TRANS = 1'b0; MONTO = 32'd0; MONTO_STB = 1'b0;
    #12;
    chk_flags("reset_flags", 6'b000000);
    chk("reset_balance", BALANCE, 64'd5000);
    RESET = 1'b1;
    step();

    // T1: three wrong PINs -> warning then lockout
    card_in();
    enter_pin(16'h1378);
    chk_flags("t1_wrong1", 6'b100000);
    enter_pin(16'h1378);
    chk_flags("t1_wrong2", 6'b110000);
    enter_pin(16'h1378);
    chk("t1_wrong3_pinc", {63'd0, PIN_INCORRECTO}, 64'd1);
    chk("t1_wrong3_bloq", {63'd0, BLOQUEO}, 64'd1);
    step();
    chk("t1_pulse_drop", {63'd0, PIN_INCORRECTO}, 64'd0);
    enter_pin(16'h3473);
    amount(1'b0, 32'd100);
    chk("t1_locked_bloq", {63'd0, BLOQUEO}, 64'd1);
    chk("t1_locked_pinc", {63'd0, PIN_INCORRECTO}, 64'd0);
    chk("t1_locked_bal", BALANCE, 64'd5000);
    TARJETA_RECIBIDA = 1'b0;
    #2 RESET = 1'b0;
    #1;
    chk_flags("t1_reset_flags", 6'b000000);
    #3 RESET = 1'b1;
    step();

    // T2: correct PIN, deposit 2000
    card_in();
    enter_pin(16'h3473);
    chk_flags("t2_pin_ok", 6'b000000);
    amount(1'b0, 32'd2000);
    chk_flags("t2_dep_flags", 6'b000100);
    chk("t2_dep_bal", BALANCE, 64'd7000);
    amount(1'b0, 32'd2000);
    chk_flags("t2_done_ignore", 6'b000000);
    chk("t2_done_bal", BALANCE, 64'd7000);
    card_out();

    // T3: two wrong, correct clears warning, withdraw 2000
    card_in();
    enter_pin(16'h1111);
    enter_pin(16'h2222);
    chk_flags("t3_warn", 6'b110000);
    enter_pin(16'h3473);
    chk_flags("t3_warn_clear", 6'b000000);
    amount(1'b1, 32'd2000);
    chk_flags("t3_wd_flags", 6'b000110);
    chk("t3_wd_bal", BALANCE, 64'd5000);
    step();
    chk_flags("t3_pulse_drop", 6'b000000);
    card_out();

    // T4: withdrawal larger than balance
    card_in();
    enter_pin(16'h3473);
    amount(1'b1, 32'd10000);
    chk_flags("t4_nsf_flags", 6'b000001);
    chk("t4_nsf_bal", BALANCE, 64'd5000);
    card_out();

    // T5: partial digits discarded on removal; amount strobe racing removal
    card_in();
    digit(4'd1);
    digit(4'd3);
    card_out();
    card_in();
    enter_pin(16'h3473);
    chk_flags("t5_pin_ok", 6'b000000);
    TARJETA_RECIBIDA = 1'b0;
    amount(1'b1, 32'd1000);
    chk_flags("t5_race_flags", 6'b000000);
    chk("t5_race_bal", BALANCE, 64'd5000);
    step();
    chk_flags("t5_race_after", 6'b000000);

    // Exact-balance withdrawal is granted and empties the account
    card_in();
    enter_pin(16'h3473);
    amount(1'b1, 32'd5000);
    chk_flags("t5_exact_flags", 6'b000110);
    chk("t5_exact_bal", BALANCE, 64'd0);
    card_out();

    // T6: async reset in the middle of WAIT_TRANS
    card_in();
    enter_pin(16'h1111);
    enter_pin(16'h3473);
    #2 RESET = 1'b0;
    #1;
    chk_flags("t6_reset_flags", 6'b000000);
    chk("t6_reset_bal", BALANCE, 64'd5000);
    #3 RESET = 1'b1;
    amount(1'b0, 32'd500);
    chk_flags("t6_idle_flags", 6'b000000);
    chk("t6_idle_bal", BALANCE, 64'd5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
